axi_ethernet_tx_frame_fifo: RTL



---
 rtl/axi_eth_pkg.sv | 18 +
 rtl/axi_eth_sdp_ram.sv | 32 +++
 rtl/axi_ethernet_tx_frame_fifo.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/axi_eth_pkg.sv
// rtl/axi_eth_pkg.sv - shared types and helpers for the AXI Ethernet transmit frame FIFO
// Purpose: write-state encoding, byte-enable width helper and drop counter width.
// Ports: none (package).
package axi_eth_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DROP  = 2'd2
  } wr_state_e;

  localparam int DROP_CNT_W = 16;

  function automatic int AXI_ETH_KEEP_W(input int tdata_w);
    return tdata_w / 8;
  endfunction

endpackage

// File: rtl/axi_eth_sdp_ram.sv
// rtl/axi_eth_sdp_ram.sv - simple dual-port RAM, one write port and one registered read port
// Purpose: frame storage array; read data appears the cycle after rd_en and holds otherwise.
// Ports: clk; wr_en/wr_addr/wr_data write port; rd_en/rd_addr read request; rd_data registered
//   read data. The array and read register have no reset.
module axi_eth_sdp_ram #(
  parameter int DATA_W = 37,
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [1 << ADDR_W];
  logic [DATA_W-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data_q <= mem[rd_addr];
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/axi_ethernet_tx_frame_fifo.sv
// rtl/axi_ethernet_tx_frame_fifo.sv - store-and-forward AXI-Stream transmit frame FIFO
// Purpose: buffers whole frames and offers a frame downstream only once its last beat is
//   stored, so the downstream bridge never sees a mid-frame stall.
// Ports: aclk sole clock; areset async active-high reset; s_axis_* ingress stream;
//   m_axis_* egress stream (first-word-fall-through output register); frame_count complete
//   frames held; drop_count dropped frames (drop build only); debug_bus
//   {5'b0, wr_state, m_axis_tvalid}.
// Config: define AXI_ETH_TXFIFO_DROP_EN to discard overflowing frames instead of
//   backpressuring the ingress.
module axi_ethernet_tx_frame_fifo
  import axi_eth_pkg::*;
#(
  parameter int C_TDATA_WIDTH = 32,
  parameter int C_DEPTH_LOG2  = 9
) (
  input  logic                       aclk,
  input  logic                       areset,
  input  logic [C_TDATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [C_TDATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic                       s_axis_tlast,
  input  logic                       s_axis_tvalid,
  output logic                       s_axis_tready,
  output logic [C_TDATA_WIDTH-1:0]   m_axis_tdata,
  output logic [C_TDATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic                       m_axis_tlast,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic [C_DEPTH_LOG2:0]      frame_count,
`ifdef AXI_ETH_TXFIFO_DROP_EN
  output logic [DROP_CNT_W-1:0]      drop_count,
`endif
  output logic [7:0]                 debug_bus
);

  localparam int KEEP_W  = AXI_ETH_KEEP_W(C_TDATA_WIDTH);
  localparam int ENTRY_W = C_TDATA_WIDTH + KEEP_W + 1;
  localparam int PTR_W   = C_DEPTH_LOG2 + 1;
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [PTR_W-1:0] DEPTH_PTR = {1'b1, {C_DEPTH_LOG2{1'b0}}};

  wr_state_e        state_q, state_d;
  logic [PTR_W-1:0] wr_cur_q, wr_cur_d;
  logic [PTR_W-1:0] wr_commit_q, wr_commit_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] frame_count_q, frame_count_d;
  logic             out_valid_q, out_valid_d;

  logic             full, accept, commit, ram_we;
  logic             pop, load, readable, out_last;
  logic [PTR_W-1:0] fetch_ptr;
  logic [ENTRY_W-1:0] ram_rd_data;

`ifdef AXI_ETH_TXFIFO_DROP_EN
  logic [DROP_CNT_W-1:0] drop_count_q, drop_count_d;
  logic                  drop_done;
`endif

  // rd_ptr retires a beat only when it leaves the output register, so the register's
  // entry still counts against capacity: total storage is exactly 2^C_DEPTH_LOG2 beats.
  assign full = (wr_cur_q - rd_ptr_q) == DEPTH_PTR;

`ifdef AXI_ETH_TXFIFO_DROP_EN
  assign s_axis_tready = !areset;
`else
  assign s_axis_tready = !areset && !full;
`endif

  assign accept = s_axis_tvalid && s_axis_tready;

  // Write-side FSM: next state, pointer updates and commit/drop events.
  always_comb begin
    state_d     = state_q;
    wr_cur_d    = wr_cur_q;
    wr_commit_d = wr_commit_q;
    ram_we      = 1'b0;
    commit      = 1'b0;
`ifdef AXI_ETH_TXFIFO_DROP_EN
    drop_done   = 1'b0;
`endif
    if (accept) begin
      case (state_q)
        ST_IDLE, ST_WRITE: begin
          if (!full) begin
            ram_we   = 1'b1;
            wr_cur_d = wr_cur_q + PTR_ONE;
            if (s_axis_tlast) begin
              wr_commit_d = wr_cur_q + PTR_ONE;
              commit      = 1'b1;
              state_d     = ST_IDLE;
            end else begin
              state_d = ST_WRITE;
            end
          end
`ifdef AXI_ETH_TXFIFO_DROP_EN
          else begin
            // Overflow: rewind to the last frame boundary and discard the rest of the
            // frame. A tlast overflow beat already ends the frame, so no DROP visit.
            wr_cur_d = wr_commit_q;
            if (s_axis_tlast) begin
              drop_done = 1'b1;
              state_d   = ST_IDLE;
            end else begin
              state_d = ST_DROP;
            end
          end
        end
        ST_DROP: begin
          if (s_axis_tlast) begin
            drop_done = 1'b1;
            state_d   = ST_IDLE;
          end
`endif
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Read side: the output register holds the beat at rd_ptr, so the next beat to fetch
  // sits one past rd_ptr whenever the register is occupied.
  assign pop       = out_valid_q && m_axis_tready;
  assign fetch_ptr = rd_ptr_q + (out_valid_q ? PTR_ONE : '0);
  assign readable  = fetch_ptr != wr_commit_q;
  assign load      = (!out_valid_q || pop) && readable;
  assign out_last  = ram_rd_data[0];

  always_comb begin
    out_valid_d   = load || (out_valid_q && !pop);
    rd_ptr_d      = pop ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    frame_count_d = frame_count_q;
    if (commit && !(pop && out_last)) begin
      frame_count_d = frame_count_q + PTR_ONE;
    end else if (!commit && pop && out_last) begin
      frame_count_d = frame_count_q - PTR_ONE;
    end
`ifdef AXI_ETH_TXFIFO_DROP_EN
    drop_count_d = drop_count_q;
    if (drop_done && (drop_count_q != {DROP_CNT_W{1'b1}})) begin
      drop_count_d = drop_count_q + DROP_CNT_W'(1);
    end
`endif
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q       <= ST_IDLE;
      wr_cur_q      <= '0;
      wr_commit_q   <= '0;
      rd_ptr_q      <= '0;
      frame_count_q <= '0;
      out_valid_q   <= 1'b0;
`ifdef AXI_ETH_TXFIFO_DROP_EN
      drop_count_q  <= '0;
`endif
    end else begin
      state_q       <= state_d;
      wr_cur_q      <= wr_cur_d;
      wr_commit_q   <= wr_commit_d;
      rd_ptr_q      <= rd_ptr_d;
      frame_count_q <= frame_count_d;
      out_valid_q   <= out_valid_d;
`ifdef AXI_ETH_TXFIFO_DROP_EN
      drop_count_q  <= drop_count_d;
`endif
    end
  end

  axi_eth_sdp_ram #(
    .DATA_W (ENTRY_W),
    .ADDR_W (C_DEPTH_LOG2)
  ) u_ram (
    .clk     (aclk),
    .wr_en   (ram_we),
    .wr_addr (wr_cur_q[C_DEPTH_LOG2-1:0]),
    .wr_data ({s_axis_tdata, s_axis_tkeep, s_axis_tlast}),
    .rd_en   (load),
    .rd_addr (fetch_ptr[C_DEPTH_LOG2-1:0]),
    .rd_data (ram_rd_data)
  );

  // The RAM read register is not reset, so egress fields are forced to zero while empty.
  assign m_axis_tvalid = out_valid_q;
  assign m_axis_tdata  = out_valid_q ? ram_rd_data[ENTRY_W-1 -: C_TDATA_WIDTH] : '0;
  assign m_axis_tkeep  = out_valid_q ? ram_rd_data[KEEP_W:1] : '0;
  assign m_axis_tlast  = out_valid_q && out_last;

  assign frame_count = frame_count_q;
`ifdef AXI_ETH_TXFIFO_DROP_EN
  assign drop_count  = drop_count_q;
`endif
  assign debug_bus   = {5'b0, state_q, out_valid_q};

endmodule
